// File: rtl/dec_stim_pkg.sv
// Shared types and constants for the decoder stimulus generator.
// Mode/state encodings, sweep opcode table, LFSR taps and default seed.
package dec_stim_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_SWEEP  = 2'd1,
    MODE_FIXED  = 2'd2,
    MODE_RVC    = 2'd3
  } stim_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stim_state_e;

  localparam int unsigned OPC_NUM = 11;

  // Base opcodes of the RV32I major instruction groups, in sweep order.
  localparam logic [6:0] OPC_TABLE [OPC_NUM] = '{
    7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
    7'h37, 7'h63, 7'h67, 7'h6F, 7'h73
  };

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

endpackage

// File: rtl/dec_stim_lfsr.sv
// Galois LFSR, right shift, advances one step per cycle with en_i high.
// Latency: q_o updates the cycle after en_i. No backpressure; en_i is the only stall.
module dec_stim_lfsr #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else if (en_i) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/dec_stim_gen.sv
// Handshaked instruction stimulus source: NUM_TRANS words per run (random/sweep/fixed/RVC).
// Latency: first word valid the cycle after start_i; a stalled word holds until instr_ready_i.
// Build option DEC_STIM_RVC_EN: mode 3 emits 16-bit compressed words, otherwise it aliases RANDOM.
module dec_stim_gen
  import dec_stim_pkg::*;
#(
  parameter int unsigned NUM_TRANS = 10,
  parameter logic [31:0] SEED      = DEFAULT_SEED,
  parameter int          CNT_W     = (NUM_TRANS < 1) ? 1 : $clog2(NUM_TRANS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [31:0]      instr_fixed_i,
  input  logic             instr_ready_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_rdata_o,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic             done_o
);

  stim_state_e      state_q;
  stim_mode_e       mode_q;
  logic [31:0]      fixed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       idx_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      word;
  logic             beat;
  logic             last_beat;
  logic             start_ok;

  assign beat      = (state_q == ST_RUN) && instr_ready_i;
  assign last_beat = beat && (cnt_q == CNT_W'(NUM_TRANS - 1));
  assign start_ok  = start_i && (state_q != ST_RUN);

  dec_stim_lfsr #(
    .WIDTH (32),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (beat),
    .q_o    (lfsr_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RANDOM;
      fixed_q <= 32'h0;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
    end else if (start_ok) begin
      mode_q  <= stim_mode_e'(mode_i);
      fixed_q <= instr_fixed_i;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      state_q <= (NUM_TRANS == 0) ? ST_DONE : ST_RUN;
    end else if (beat) begin
      // The final beat parks in DONE, so the counter saturates at NUM_TRANS.
      cnt_q <= cnt_q + 1'b1;
      idx_q <= (idx_q == 4'(OPC_NUM - 1)) ? 4'd0 : idx_q + 4'd1;
      if (last_beat) begin
        state_q <= ST_DONE;
      end
    end
  end

  always_comb begin
    word = {lfsr_q[31:2], 2'b11};
    case (mode_q)
      MODE_SWEEP: word = {lfsr_q[31:7], OPC_TABLE[idx_q]};
      MODE_FIXED: word = fixed_q;
`ifdef DEC_STIM_RVC_EN
      // Quadrant 2'b11 would mark a 32-bit encoding, so it is folded onto quadrant 0.
      MODE_RVC:   word = {16'h0, lfsr_q[15:2], (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0]};
`endif
      default:    word = {lfsr_q[31:2], 2'b11};
    endcase
  end

  assign instr_valid_o = (state_q == ST_RUN);
  assign instr_rdata_o = instr_valid_o ? word : 32'h0;
  assign trans_cnt_o   = cnt_q;
  assign done_o        = (state_q == ST_DONE);

endmodule

// File: tb/tb_dec_stim_gen.sv
// Scoreboarded bench for dec_stim_gen: expected words come from a plain Galois model,
// a negedge monitor pops and compares on every handshake and checks stalled words hold.
module tb_dec_stim_gen;

  localparam int          NT   = 12;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  typedef struct {
    logic [31:0] w;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start0;
  logic        ready;
  logic [1:0]  mode;
  logic [31:0] fixed;
  logic        vld, vld0, done, done0;
  logic [31:0] rdata, rdata0;
  logic [3:0]  cnt;
  logic [0:0]  cnt0;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] lf_m;
  logic [6:0]  opc [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  dec_stim_gen #(.NUM_TRANS(NT), .SEED(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .instr_fixed_i(fixed), .instr_ready_i(ready), .instr_valid_o(vld),
    .instr_rdata_o(rdata), .trans_cnt_o(cnt), .done_o(done)
  );

  dec_stim_gen #(.NUM_TRANS(0), .SEED(SEED)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .mode_i(2'd0),
    .instr_fixed_i(32'h0), .instr_ready_i(1'b1), .instr_valid_o(vld0),
    .instr_rdata_o(rdata0), .trans_cnt_o(cnt0), .done_o(done0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [1:0] m, input int k,
                                           input logic [31:0] lf, input logic [31:0] fx);
    logic [1:0] q;
    q = (lf[1:0] == 2'b11) ? 2'b00 : lf[1:0];
    case (m)
      2'd1: return {lf[31:7], opc[k % 11]};
      2'd2: return fx;
`ifdef DEC_STIM_RVC_EN
      2'd3: return {16'h0, lf[15:2], q};
`endif
      default: return {lf[31:2], 2'b11};
    endcase
  endfunction

  // Monitor: compares every accepted beat and checks held data across stalls.
  initial begin : monitor
    bit          stalled;
    logic [31:0] stall_word;
    exp_t        e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled && rst_n === 1'b1) begin
        check("stall_valid", {31'h0, vld}, 32'h1);
        check("stall_rdata", rdata, stall_word);
      end
      stalled = 1'b0;
      if (rst_n === 1'b1 && vld === 1'b1) begin
        if (ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", rdata, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("beat_rdata", rdata, e.w);
            check("beat_cnt", {28'h0, cnt}, 32'(e.idx));
          end
        end else begin
          stalled    = 1'b1;
          stall_word = rdata;
        end
      end
    end
  end

  task automatic run(input logic [1:0] m, input logic [31:0] fx, input bit stall,
                     input int abort_at);
    bit fin;
    for (int k = 0; k < NT; k++) begin
      exp_q.push_back('{exp_word(m, k, lf_m, fx), k});
      lf_m = step(lf_m);
    end
    mode  = m;
    fixed = fx;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fixed = 32'($urandom);
    mode  = 2'($urandom);
    check("first_valid_latency", {31'h0, vld}, 32'h1);
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (abort_at > 0 && int'(cnt) == abort_at) return;
      ready = stall ? pat[c % 4] : 1'b1;
      start = (c == 5);
      @(posedge clk); #1;
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    ready = 1'b1;
    check("run_finished", {31'h0, fin}, 32'h1);
    check("done_after_run", {31'h0, done}, 32'h1);
    check("cnt_after_run", {28'h0, cnt}, 32'(NT));
    check("valid_after_run", {31'h0, vld}, 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    ready  = 1'b1;
    mode   = 2'd0;
    fixed  = 32'h0;
    lf_m   = SEED;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, vld}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_cnt", {28'h0, cnt}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_done0", {31'h0, done0}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-length run: straight to DONE, never valid.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("zero_done", {31'h0, done0}, 32'h1);
    check("zero_valid", {31'h0, vld0}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("zero_valid_hold", {31'h0, vld0}, 32'h0);
      check("zero_done_hold", {31'h0, done0}, 32'h1);
    end

    run(2'd2, 32'h0000_0013, 1'b0, 0);
    run(2'd1, 32'h0, 1'b0, 0);
    run(2'd0, 32'h0, 1'b1, 0);
    run(2'd3, 32'h0, 1'b0, 0);
    run(2'd1, 32'h0, 1'b1, 0);

    // Abort after 4 beats; the re-run must restart the LFSR from the seed.
    run(2'd0, 32'h0, 1'b0, 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", {31'h0, vld}, 32'h0);
    check("abort_cnt", {28'h0, cnt}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    lf_m = SEED;
    @(posedge clk); #1;
    run(2'd0, 32'h0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
